// File: rtl/cpr_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : cpr_stream_packer
// Purpose  : Serialises compressed blocks as {tag, payload} records into a
//            contiguous MSB-first bit stream, emitted as fixed-width words
//            over valid/ready, with a flush to close the stream.
// Revision : 1.0 - initial release
// ============================================================================
module cpr_stream_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2,
  parameter int LEN_WIDTH  = 9,
  parameter int FILL_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [DATA_WIDTH*8-1:0] dataIn,
  input  logic [LEN_WIDTH-1:0]    lenIn,
  input  logic [TAG_WIDTH*8-1:0]  tagIn,
  input  logic                    flushIn,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [DATA_WIDTH*8-1:0] outData,
  output logic                    outLast,
  output logic                    flushDone,
  output logic                    errLen
);

  localparam int c_W   = DATA_WIDTH * 8;
  localparam int c_T   = TAG_WIDTH * 8;
  localparam int c_ACC = 3 * c_W;
  localparam logic [FILL_WIDTH-1:0] c_FILL_W   = FILL_WIDTH'(c_W);
  localparam logic [FILL_WIDTH-1:0] c_FILL_T   = FILL_WIDTH'(c_T);
  // Highest fill at which a maximum-size record still fits in the accumulator
  localparam logic [FILL_WIDTH-1:0] c_FILL_MAX = FILL_WIDTH'(2 * c_W - c_T);
  localparam logic [LEN_WIDTH-1:0]  c_LEN_MAX  = LEN_WIDTH'(c_W);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [c_ACC-1:0]      r_acc;
  logic [c_ACC-1:0]      w_accBase;
  logic [c_ACC-1:0]      w_accNext;
  logic [c_ACC-1:0]      w_recVec;
  logic [FILL_WIDTH-1:0] r_fill;
  logic [FILL_WIDTH-1:0] w_fillBase;
  logic [FILL_WIDTH-1:0] w_fillNext;
  logic [FILL_WIDTH-1:0] w_rec;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [c_W-1:0]        w_mask;
  logic [c_W+c_T-1:0]    w_recBits;
  logic                  r_inReady;
  logic                  r_outValid;
  logic                  r_outLast;
  logic                  r_flushDone;
  logic                  r_errLen;
  logic                  w_accept;
  logic                  w_emit;
  logic                  w_lenErr;
  logic                  w_flushDoneNext;

  assign w_accept  = inValid & r_inReady;
  assign w_emit    = r_outValid & outReady;
  assign w_lenErr  = (lenIn > c_LEN_MAX);
  assign w_len     = w_lenErr ? c_LEN_MAX : lenIn;
  assign w_rec     = c_FILL_T + FILL_WIDTH'(w_len);
  // Keep only the top w_len payload bits so the bits below the record stay zero
  assign w_mask    = ~({c_W{1'b1}} >> w_len);
  assign w_recBits = {tagIn, dataIn & w_mask};

  // Next accumulator/fill: drain a word first, then append the record behind it
  always_comb begin
    w_accBase  = r_acc;
    w_fillBase = r_fill;
    if (w_emit) begin
      w_accBase  = r_acc << c_W;
      w_fillBase = (r_fill > c_FILL_W) ? (r_fill - c_FILL_W) : '0;
    end
    w_recVec   = {w_recBits, {(c_ACC - c_W - c_T){1'b0}}} >> w_fillBase;
    w_accNext  = w_accept ? (w_accBase | w_recVec) : w_accBase;
    w_fillNext = w_accept ? (w_fillBase + w_rec) : w_fillBase;

    w_stateNext     = r_state;
    w_flushDoneNext = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (flushIn) begin
          w_stateNext     = ST_FLUSH;
          // Nothing buffered: report completion during the single FLUSH cycle
          w_flushDoneNext = (w_fillNext == '0);
        end
      end
      ST_FLUSH: begin
        if (r_fill == '0) begin
          w_stateNext = ST_RUN;
        end else if (w_emit && r_outLast) begin
          w_accNext       = '0;
          w_fillNext      = '0;
          w_stateNext     = ST_RUN;
          w_flushDoneNext = 1'b1;
        end
      end
      default: w_stateNext = ST_RUN;
    endcase
  end

  // State, storage and registered handshake/status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_acc       <= '0;
      r_fill      <= '0;
      r_inReady   <= 1'b0;
      r_outValid  <= 1'b0;
      r_outLast   <= 1'b0;
      r_flushDone <= 1'b0;
      r_errLen    <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_acc       <= w_accNext;
      r_fill      <= w_fillNext;
      r_flushDone <= w_flushDoneNext;
      r_errLen    <= r_errLen | (w_accept & w_lenErr);
      if (w_stateNext == ST_RUN) begin
        r_inReady  <= (w_fillNext <= c_FILL_MAX);
        r_outValid <= (w_fillNext >= c_FILL_W);
        r_outLast  <= 1'b0;
      end else begin
        r_inReady  <= 1'b0;
        r_outValid <= (w_fillNext != '0);
        r_outLast  <= (w_fillNext <= c_FILL_W);
      end
    end
  end

  assign inReady   = r_inReady;
  assign outValid  = r_outValid;
  assign outData   = r_acc[c_ACC-1 -: c_W];
  assign outLast   = r_outLast;
  assign flushDone = r_flushDone;
  assign errLen    = r_errLen;

endmodule
`default_nettype wire

// File: tb/tb_cpr_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpr_stream_packer
// Purpose  : Directed bench for cpr_stream_packer; a bit-level queue models
//            the expected stream and each emitted word is checked against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpr_stream_packer;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [255:0] dataIn = '0;
  logic [8:0]   lenIn = '0;
  logic [15:0]  tagIn = '0;
  logic         flushIn = 1'b0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [255:0] outData;
  logic         outLast;
  logic         flushDone;
  logic         errLen;

  int nTests = 0;
  int nFail  = 0;
  int wordsSeen = 0;
  bit mq[$];
  bit flushPending = 1'b0;

  cpr_stream_packer #(
    .DATA_WIDTH(32), .TAG_WIDTH(2), .LEN_WIDTH(9), .FILL_WIDTH(10)
  ) dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady),
    .dataIn(dataIn), .lenIn(lenIn), .tagIn(tagIn), .flushIn(flushIn),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .outLast(outLast), .flushDone(flushDone), .errLen(errLen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [255:0] randWord();
    logic [255:0] w;
    for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic logic [255:0] peekWord();
    logic [255:0] w;
    for (int i = 0; i < W; i++) w[W-1-i] = (i < mq.size()) ? mq[i] : 1'b0;
    return w;
  endfunction

  task automatic pushRec(input logic [15:0] tag, input logic [255:0] data, input logic [8:0] len);
    int l;
    l = (len > 9'd256) ? 256 : int'(len);
    for (int i = 15; i >= 0; i--) mq.push_back(tag[i]);
    for (int i = 0; i < l; i++) mq.push_back(data[W-1-i]);
  endtask

  // Present a record (optionally with flush) until accepted; entry/exit at posedge+1
  task automatic sendRec(input logic [15:0] tag, input logic [255:0] data,
                         input logic [8:0] len, input bit fl);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    inValid = 1'b1; tagIn = tag; dataIn = data; lenIn = len; flushIn = fl;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = inReady;
      if (!ok) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("acceptInTime", 256'(ok), 256'(1));
    if (ok) begin
      @(posedge clk);
      pushRec(tag, data, len);
      if (fl) flushPending = (mq.size() != 0);
      #1;
    end
    inValid = 1'b0; flushIn = 1'b0;
  endtask

  task automatic doFlush();
    flushIn = 1'b1;
    @(posedge clk);
    flushPending = (mq.size() != 0);
    #1;
    flushIn = 1'b0;
  endtask

  task automatic waitFlushDone();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = flushDone;
    end
    check("flushDoneSeen", 256'(seen), 256'(1));
    @(negedge clk);
    check("flushDonePulse", 256'(flushDone), 256'(0));
    check("streamDrained", 256'(mq.size()), 256'(0));
    check("lastWordSeen", 256'(flushPending), 256'(0));
    @(posedge clk); #1;
  endtask

  // Scoreboard: every handshaken word must match the head of the modelled stream
  always @(negedge clk) begin
    if (reset && outValid && outReady) begin
      logic [255:0] expWord;
      logic         expLast;
      check("wordExpected", 256'(mq.size() != 0), 256'(1));
      expLast = flushPending && (mq.size() <= W);
      for (int i = 0; i < W; i++) expWord[W-1-i] = (mq.size() != 0) ? mq.pop_front() : 1'b0;
      check("outData", outData, expWord);
      check("outLast", 256'(outLast), 256'(expLast));
      if (expLast) flushPending = 1'b0;
      wordsSeen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d[4];
    int w0;

    // Reset state
    #3;
    check("resetOutputs", 256'({inReady, outValid, outLast, flushDone, errLen}), 256'(0));
    check("resetData", outData, 256'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("readyBeforeEdge", 256'(inReady), 256'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("readyAfterReset", 256'(inReady), 256'(1));
    @(posedge clk); #1;

    // Single record closed by a flush in the same cycle
    sendRec(16'hA5A5, {256{1'b1}}, 9'd240, 1'b1);
    @(negedge clk);
    check("single.valid", 256'(outValid), 256'(1));
    check("single.last", 256'(outLast), 256'(1));
    check("single.data", outData, {16'hA5A5, {240{1'b1}}});
    check("single.readyLow", 256'(inReady), 256'(0));
    @(posedge clk); #1;
    outReady = 1'b1;
    waitFlushDone();

    // Back-to-back full records with the consumer always ready
    w0 = wordsSeen;
    for (int k = 0; k < 4; k++) sendRec(16'(k + 1), randWord(), 9'd256, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("b2b.words", 256'(wordsSeen - w0), 256'(4));
    check("b2b.fill", 256'(dut.r_fill), 256'(64));
    doFlush();
    waitFlushDone();

    // Backpressure: inReady must drop and the head word must hold
    outReady = 1'b0;
    for (int k = 0; k < 4; k++) d[k] = randWord();
    sendRec(16'h1111, d[0], 9'd256, 1'b0);
    sendRec(16'h2222, d[1], 9'd256, 1'b0);
    inValid = 1'b1; tagIn = 16'h3333; dataIn = d[2]; lenIn = 9'd256;
    repeat (4) begin
      @(negedge clk);
      check("bp.readyLow", 256'(inReady), 256'(0));
      check("bp.valid", 256'(outValid), 256'(1));
      check("bp.holdData", outData, peekWord());
      @(posedge clk); #1;
    end
    check("bp.fill", 256'(dut.r_fill), 256'(544));
    outReady = 1'b1;
    sendRec(16'h3333, d[2], 9'd256, 1'b0);
    sendRec(16'h4444, d[3], 9'd256, 1'b0);
    doFlush();
    waitFlushDone();

    // Sixteen tag-only records make exactly one word
    w0 = wordsSeen;
    for (int k = 0; k < 16; k++) sendRec(16'(16'hC000 + k), randWord(), 9'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("zero.words", 256'(wordsSeen - w0), 256'(1));
    check("zero.noErr", 256'(errLen), 256'(0));

    // Over-long record is clamped and flags a sticky error
    sendRec(16'hBEEF, randWord(), 9'd300, 1'b0);
    @(negedge clk);
    check("clamp.err", 256'(errLen), 256'(1));
    @(posedge clk); #1;
    sendRec(16'h0F0F, randWord(), 9'd50, 1'b0);
    @(negedge clk);
    check("clamp.sticky", 256'(errLen), 256'(1));
    @(posedge clk); #1;
    doFlush();
    waitFlushDone();
    check("clamp.stickyAfterFlush", 256'(errLen), 256'(1));

    // Flush with nothing buffered
    doFlush();
    @(negedge clk);
    check("empty.flushDone", 256'(flushDone), 256'(1));
    check("empty.readyLow", 256'(inReady), 256'(0));
    check("empty.noValid", 256'(outValid), 256'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("empty.pulseEnds", 256'(flushDone), 256'(0));
    check("empty.readyBack", 256'(inReady), 256'(1));
    @(posedge clk); #1;

    // Asynchronous reset with 100 bits buffered
    outReady = 1'b0;
    sendRec(16'h5A5A, randWord(), 9'd84, 1'b0);
    @(negedge clk);
    check("rst.noWordYet", 256'(outValid), 256'(0));
    #2;
    reset = 1'b0;
    #1;
    check("rst.outputs", 256'({inReady, outValid, outLast, flushDone, errLen}), 256'(0));
    check("rst.data", outData, 256'(0));
    mq.delete();
    flushPending = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst.idle", 256'(outValid), 256'(0));
    @(posedge clk); #1;
    sendRec(16'h9ABC, randWord(), 9'd100, 1'b1);
    waitFlushDone();
    check("rst.errCleared", 256'(errLen), 256'(0));

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
